regfile_write_arbiter: RTL and testbench

//  Shares the single write port of the CPU register bank (built from N-bit

---
 rtl/regfile_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among N_REQ writeback requesters.
// Build option RF_ARB_PRIO0_EN: requester 0 wins every IDLE cycle, round-robin rotates over 1..N_REQ-1.
module regfile_write_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      locked
);

   localparam logic IDLE   = 1'b0;
   localparam logic LOCKED = 1'b1;

   logic              state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  winner;
   logic              found;
   logic [IDX_W-1:0]  rr_next;
   logic [IDX_W-1:0]  acc_idx;
   logic              accept;
   logic              acc_last;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;

   assign locked = (state == LOCKED);

   // Search starts at rr_ptr; the first valid requester found wins.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      found  = 1'b0;
      winner = '0;
      cand   = '0;
`ifdef RF_ARB_PRIO0_EN
      if (req_valid[0]) begin
         found  = 1'b1;
         winner = '0;
      end
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && cand != '0 && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`else
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`endif
   end

   always_comb begin
      rr_next = rr_ptr;
`ifdef RF_ARB_PRIO0_EN
      if (winner == IDX_W'(N_REQ - 1))
         rr_next = IDX_W'(1);
      else if (winner != '0)
         rr_next = winner + IDX_W'(1);
`else
      if (winner == IDX_W'(N_REQ - 1))
         rr_next = '0;
      else
         rr_next = winner + IDX_W'(1);
`endif
   end

   always_comb begin
      req_ready = '0;
      if (!reset) begin
         if (state == LOCKED)
            req_ready[grant_id] = 1'b1;
         else if (found)
            req_ready[winner] = 1'b1;
      end
   end

   assign acc_idx  = (state == LOCKED) ? grant_id : winner;
   assign accept   = (|req_ready) && req_valid[acc_idx];
   assign acc_last = req_last[acc_idx];
   assign acc_addr = req_addr[int'(acc_idx)*ADDR_W +: ADDR_W];
   assign acc_data = req_data[int'(acc_idx)*DATA_W +: DATA_W];

   // Address 0 is the hardwired zero register: accepted but never written.
   always_ff @(posedge clock) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_en <= accept && (acc_addr != '0);
         if (accept && (acc_addr != '0)) begin
            wr_addr <= acc_addr;
            wr_data <= acc_data;
         end
         if (accept) begin
            if (state == IDLE) begin
               grant_id <= winner;
               rr_ptr   <= rr_next;
               state    <= acc_last ? IDLE : LOCKED;
            end else if (acc_last) begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, round-robin, bursts, zero register,
// reset mid-burst and the RF_ARB_PRIO0_EN priority mode.
module tb_regfile_write_arbiter;

   localparam int N_REQ  = 4;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   logic                    clock;
   logic                    reset;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic [1:0]              grant_id;
   logic                    locked;

   int n_cmp = 0;
   int n_mis = 0;

   regfile_write_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .locked    (locked)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Requester obligation: addr/data stay stable while a beat is stalled.
   logic [N_REQ-1:0]        stall_q = '0;
   logic [N_REQ*ADDR_W-1:0] addr_q  = '0;
   logic [N_REQ*DATA_W-1:0] data_q  = '0;
   always @(posedge clock) begin
      for (int i = 0; i < N_REQ; i++)
         if (stall_q[i] && req_valid[i] &&
             (req_addr[i*ADDR_W +: ADDR_W] !== addr_q[i*ADDR_W +: ADDR_W] ||
              req_data[i*DATA_W +: DATA_W] !== data_q[i*DATA_W +: DATA_W]))
            $error("requester %0d changed addr/data while stalled", i);
      stall_q <= req_valid & ~req_ready & {N_REQ{~reset}};
      addr_q  <= req_addr;
      data_q  <= req_data;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[i]                = v;
      req_last[i]                 = l;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b1, ADDR_W'(i + 1), 32'hA000_0000 + i);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++;
         if (req_ready !== 4'b0000) begin
            n_mis++; $display("FAIL reset_ready c%0d: got %b want 0000", c, req_ready);
         end
         step();
         n_cmp++;
         if (wr_en !== 1'b0 || grant_id !== 2'd0 || locked !== 1'b0) begin
            n_mis++; $display("FAIL reset_outputs c%0d: got wr_en=%b grant=%0d locked=%b want 0/0/0",
                              c, wr_en, grant_id, locked);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (req_ready !== 4'(1 << exp_seq[c])) begin
            n_mis++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, 4'(1 << exp_seq[c]));
         end
         step();
         n_cmp++;
         if (wr_en !== 1'b1 || wr_addr !== 4'(exp_seq[c] + 1) ||
             wr_data !== 32'hA000_0000 + exp_seq[c] || grant_id !== 2'(exp_seq[c]) || locked !== 1'b0) begin
            n_mis++; $display("FAIL rr_write c%0d: got en=%b a=%0d d=%h g=%0d l=%b want 1/%0d/%h/%0d/0",
                              c, wr_en, wr_addr, wr_data, grant_id, locked,
                              exp_seq[c] + 1, 32'hA000_0000 + exp_seq[c], exp_seq[c]);
         end
      end
      clear_req();
   endtask

   task automatic test_idle();
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
         n_mis++; $display("FAIL idle_ready: got %b want 0000", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b0 || wr_addr !== 4'd1 || wr_data !== 32'hA000_0000 || grant_id !== 2'd0) begin
         n_mis++; $display("FAIL idle_hold: got en=%b a=%0d d=%h g=%0d want 0/1/a0000000/0",
                           wr_en, wr_addr, wr_data, grant_id);
      end
   endtask

   task automatic test_burst();
      // rr_ptr is 1 here: req1 wins over req2 and then owns the port.
      set_req(1, 1'b1, 1'b0, 4'd5, 32'h0000_00B5);
      set_req(2, 1'b1, 1'b1, 4'd9, 32'h0000_00C9);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010 || locked !== 1'b0) begin
         n_mis++; $display("FAIL burst_b1_ready: got %b locked=%b want 0010/0", req_ready, locked);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 32'h0000_00B5 || grant_id !== 2'd1 || locked !== 1'b1) begin
         n_mis++; $display("FAIL burst_b1_write: got en=%b a=%0d d=%h g=%0d l=%b want 1/5/b5/1/1",
                           wr_en, wr_addr, wr_data, grant_id, locked);
      end
      set_req(1, 1'b1, 1'b0, 4'd6, 32'h0000_00B6);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010) begin
         n_mis++; $display("FAIL burst_b2_ready: got %b want 0010", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd6 || wr_data !== 32'h0000_00B6 || locked !== 1'b1) begin
         n_mis++; $display("FAIL burst_b2_write: got en=%b a=%0d d=%h l=%b want 1/6/b6/1",
                           wr_en, wr_addr, wr_data, locked);
      end
      // Owner pauses mid-burst: port held, req2 still locked out.
      set_req(1, 1'b0, 1'b0, 4'd6, 32'h0000_00B6);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010) begin
         n_mis++; $display("FAIL burst_gap_ready: got %b want 0010", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b0 || wr_addr !== 4'd6 || locked !== 1'b1 || grant_id !== 2'd1) begin
         n_mis++; $display("FAIL burst_gap_hold: got en=%b a=%0d l=%b g=%0d want 0/6/1/1",
                           wr_en, wr_addr, locked, grant_id);
      end
      set_req(1, 1'b1, 1'b1, 4'd7, 32'h0000_00B7);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0010) begin
         n_mis++; $display("FAIL burst_b3_ready: got %b want 0010", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 32'h0000_00B7 || locked !== 1'b0) begin
         n_mis++; $display("FAIL burst_b3_write: got en=%b a=%0d d=%h l=%b want 1/7/b7/0",
                           wr_en, wr_addr, wr_data, locked);
      end
      set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0100) begin
         n_mis++; $display("FAIL burst_next_ready: got %b want 0100", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd9 || wr_data !== 32'h0000_00C9 || grant_id !== 2'd2) begin
         n_mis++; $display("FAIL burst_next_write: got en=%b a=%0d d=%h g=%0d want 1/9/c9/2",
                           wr_en, wr_addr, wr_data, grant_id);
      end
      clear_req();
   endtask

   task automatic test_zero_reg();
      // rr_ptr is 3; req0 is the only requester so it wins after the wrap.
      set_req(0, 1'b1, 1'b1, 4'd0, 32'h0000_DEAD);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
         n_mis++; $display("FAIL zero_ready: got %b want 0001", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b0 || wr_addr !== 4'd9 || wr_data !== 32'h0000_00C9 || grant_id !== 2'd0) begin
         n_mis++; $display("FAIL zero_nowrite: got en=%b a=%0d d=%h g=%0d want 0/9/c9/0",
                           wr_en, wr_addr, wr_data, grant_id);
      end
      clear_req();
   endtask

   task automatic test_reset_mid_burst();
      // rr_ptr is 1; only req3 valid.
      set_req(3, 1'b1, 1'b0, 4'd10, 32'h0000_0D0A);
      #1;
      n_cmp++;
      if (req_ready !== 4'b1000) begin
         n_mis++; $display("FAIL rmb_b1_ready: got %b want 1000", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd10 || locked !== 1'b1 || grant_id !== 2'd3) begin
         n_mis++; $display("FAIL rmb_b1_write: got en=%b a=%0d l=%b g=%0d want 1/10/1/3",
                           wr_en, wr_addr, locked, grant_id);
      end
      set_req(3, 1'b1, 1'b0, 4'd11, 32'h0000_0D0B);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
         n_mis++; $display("FAIL rmb_reset_ready: got %b want 0000", req_ready);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b0 || locked !== 1'b0 || grant_id !== 2'd0 || wr_addr !== 4'd0 || wr_data !== 32'd0) begin
         n_mis++; $display("FAIL rmb_after_reset: got en=%b l=%b g=%0d a=%0d d=%h want 0/0/0/0/0",
                           wr_en, locked, grant_id, wr_addr, wr_data);
      end
      reset = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b1, ADDR_W'(i + 1), 32'hA000_0000 + i);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
         n_mis++; $display("FAIL rmb_rrptr0: got %b want 0001", req_ready);
      end
      clear_req();
   endtask

   task automatic test_prio0();
`ifdef RF_ARB_PRIO0_EN
      int exp_seq[4] = '{0, 0, 0, 0};
`else
      int exp_seq[4] = '{0, 2, 0, 2};
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_req(0, 1'b1, 1'b1, 4'd1, 32'hA000_0000);
      set_req(2, 1'b1, 1'b1, 4'd3, 32'hA000_0002);
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (req_ready !== 4'(1 << exp_seq[c])) begin
            n_mis++; $display("FAIL prio_ready c%0d: got %b want %b", c, req_ready, 4'(1 << exp_seq[c]));
         end
         step();
         n_cmp++;
         if (wr_en !== 1'b1 || grant_id !== 2'(exp_seq[c]) || wr_addr !== 4'(exp_seq[c] + 1)) begin
            n_mis++; $display("FAIL prio_write c%0d: got en=%b g=%0d a=%0d want 1/%0d/%0d",
                              c, wr_en, grant_id, wr_addr, exp_seq[c], exp_seq[c] + 1);
         end
      end
      clear_req();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_addr  = '0;
      req_data  = '0;
      test_reset();
      test_round_robin();
      test_idle();
      test_burst();
      test_zero_reg();
      test_reset_mid_burst();
      test_prio0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
